pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/pc_fetch_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch types, constants and the PC increment helper.
// Build option FETCH_PREFETCH_EN raises the outstanding-entry capacity from one to two.
package defs;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam int          FETCH_CAP_MAX = 2;
    localparam logic [32:0] MEM_SIZE      = 33'h1_0000_0000;

`ifdef FETCH_PREFETCH_EN
    localparam int FETCH_CAP = FETCH_CAP_MAX;
`else
    localparam int FETCH_CAP = 1;
`endif

    // Sequential fetch wraps around the top of the byte address space.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        logic [32:0] sum;
        sum = {1'b0, pc} + {1'b0, PC_STEP};
        return 32'(sum % MEM_SIZE);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small shift-style FIFO (depth 1 or 2) with same-cycle push+pop and a synchronous clear.
// Used for both the request-address FIFO and the response buffer of pc_fetch_ctrl.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             do_push;
    logic             do_pop;
    logic [1:0]       wr_idx;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign wr_idx  = count - {1'b0, do_pop};
    assign rdata   = slot0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset because the head word drives outputs that must read zero in reset.
            slot0 <= '0;
            slot1 <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            if (do_push && wr_idx == 2'd0) begin
                slot0 <= wdata;
            end else if (do_pop) begin
                slot0 <= slot1;
            end
            if (do_push && wr_idx == 2'd1) begin
                slot1 <= wdata;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: issues PC requests, pairs in-order responses with their address,
// buffers them for decode and flushes on redirect. FETCH_PREFETCH_EN enables two-deep prefetch.
module pc_fetch_ctrl
    import defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [1:0]   kill_cnt;
    logic         live;
    logic         af_full, af_empty, rb_full, rb_empty;
    logic [1:0]   af_count, rb_count;
    logic [31:0]  af_addr;
    logic [63:0]  rb_head;
    logic         accept, pop, keep_rsp;
    logic [1:0]   occ_after_pop, kill_load;

    // Occupancy already credits the slot decode frees this cycle, so fetch keeps pace with decode.
    assign pop           = !rb_empty && inst_ready;
    assign occ_after_pop = af_count + rb_count - {1'b0, pop};
    assign req_valid     = live && (state == RUN) && (occ_after_pop < 2'(FETCH_CAP));
    assign req_addr      = pc;
    assign accept        = req_valid && req_ready;
    assign keep_rsp      = rsp_valid && (state == RUN) && !redirect_valid;
    assign kill_load     = kill_cnt + af_count + {1'b0, accept} - {1'b0, rsp_valid};
    assign inst_valid    = !rb_empty;
    assign inst_pc       = rb_head[63:32];
    assign inst_data     = rb_head[31:0];

    fetch_fifo #(.WIDTH(32), .DEPTH(FETCH_CAP)) u_addr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect_valid),
        .push  (accept),
        .wdata (pc),
        .pop   (keep_rsp),
        .rdata (af_addr),
        .full  (af_full),
        .empty (af_empty),
        .count (af_count)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(FETCH_CAP)) u_rsp_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect_valid),
        .push  (keep_rsp),
        .wdata ({af_addr, rsp_data}),
        .pop   (pop),
        .rdata (rb_head),
        .full  (rb_full),
        .empty (rb_empty),
        .count (rb_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            kill_cnt <= '0;
            live     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
            live <= 1'b1;
            if (redirect_valid) begin
                pc       <= redirect_pc;
                kill_cnt <= kill_load;
                state    <= (kill_load != 2'd0) ? FLUSH : RUN;
            end else begin
                if (accept) begin
                    pc <= next_pc(pc);
                end
                if (state == FLUSH && rsp_valid) begin
                    kill_cnt <= kill_cnt - 2'd1;
                    if (kill_cnt == 2'd1) begin
                        state <= RUN;
                    end
                end
            end
        end
    end

    a_rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (kill_cnt != 2'd0 || !af_empty));
    a_no_addr_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(accept && af_full));
    a_no_buf_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(keep_rsp && rb_full && !pop));

endmodule
